// File: rtl/spi_burst_pkg.sv
// rtl/spi_burst_pkg.sv - command encodings and FSM states for the SPI burst RAM slave
package spi_burst_pkg;

  localparam int CMD_BITS = 2;

  localparam logic [CMD_BITS-1:0] CMD_WR   = 2'b00;
  localparam logic [CMD_BITS-1:0] CMD_RD   = 2'b01;
  localparam logic [CMD_BITS-1:0] CMD_RSV  = 2'b10;
  localparam logic [CMD_BITS-1:0] CMD_STAT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    DUMMY,
    RDATA,
    STATUS,
    IGNORE
  } state_e;

endpackage

// File: rtl/burst_sp_ram.sv
// rtl/burst_sp_ram.sv - single-port synchronous RAM with registered read data
module burst_sp_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end else if (re) begin
      dout_q <= mem[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/spi_burst_ram_slave.sv
// rtl/spi_burst_ram_slave.sv - SPI slave with burst auto-increment access to an internal RAM
module spi_burst_ram_slave
  import spi_burst_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_DEPTH    = 256,
  parameter int DUMMY_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int TW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = 16;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_inc, addr_in;
  logic [TW-2:0]         rx_q, rx_d;
  logic [TW-1:0]         rx_next, tx_q, tx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d, word_in, ram_dout;
  logic                  miso_q, miso_d;
  logic [CMD_BITS-1:0]   cmd_in;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;

  burst_sp_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk (clk),
    .we  (wr_pend_q),
    .re  (ram_re),
    .addr(ram_addr),
    .din (wr_data_q),
    .dout(ram_dout)
  );

  always_comb begin
    rx_next   = {rx_q, MOSI};
    cmd_in    = rx_next[CMD_BITS-1:0];
    addr_in   = rx_next[ADDR_WIDTH-1:0];
    word_in   = rx_next[DATA_WIDTH-1:0];
    ptr_inc   = (ptr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : ptr_q + ADDR_WIDTH'(1);
    state_d   = state_q;
    ptr_d     = ptr_q;
    rx_d      = rx_next[TW-2:0];
    tx_d      = tx_q << 1;
    cnt_d     = cnt_q + CW'(1);
    rd_d      = rd_q;
    wr_pend_d = 1'b0;
    wr_data_d = wr_data_q;
    miso_d    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = ptr_q;

    // A completed word commits even if the frame ends on the same edge.
    if (wr_pend_q) begin
      ptr_d = ptr_inc;
    end

    if (SS_n) begin
      state_d = IDLE;
      rx_d    = '0;
      tx_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CMD;
          rx_d    = '0;
          cnt_d   = '0;
        end
        CMD: begin
          if (cnt_q == CW'(CMD_BITS - 1)) begin
            cnt_d = '0;
            rd_d  = (cmd_in == CMD_RD);
            case (cmd_in)
              CMD_WR, CMD_RD: state_d = ADDR;
              CMD_RSV:        state_d = IGNORE;
              default: begin
                state_d = STATUS;
                tx_d    = TW'(ptr_q) << (TW - ADDR_WIDTH);
              end
            endcase
          end
        end
        ADDR: begin
          if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
            cnt_d   = '0;
            ptr_d   = ADDR_WIDTH'(32'(addr_in) % MEM_DEPTH);
            state_d = rd_q ? DUMMY : WDATA;
          end
        end
        WDATA: begin
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d     = '0;
            wr_pend_d = 1'b1;
            wr_data_d = word_in;
          end
        end
        DUMMY: begin
          ram_re = 1'b1;
          if (cnt_q == CW'(DUMMY_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = RDATA;
          end
        end
        RDATA: begin
          // Word launch: the prefetched word goes out and the next one is fetched.
          if (cnt_q == '0) begin
            miso_d   = ram_dout[DATA_WIDTH-1];
            tx_d     = TW'(ram_dout) << (TW - DATA_WIDTH + 1);
            ptr_d    = ptr_inc;
            ram_re   = 1'b1;
            ram_addr = ptr_inc;
          end else begin
            miso_d = tx_q[TW-1];
          end
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d = '0;
          end
        end
        STATUS: begin
          miso_d = tx_q[TW-1];
          cnt_d  = cnt_q;
        end
        IGNORE: begin
          cnt_d = cnt_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_data_q <= '0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_pend_q <= wr_pend_d;
      wr_data_q <= wr_data_d;
      miso_q    <= miso_d;
    end
  end

  assign MISO = miso_q;

endmodule

// File: tb/tb_spi_burst_ram_slave.sv
// tb/tb_spi_burst_ram_slave.sv - self-checking bench for spi_burst_ram_slave
module tb_spi_burst_ram_slave;
  import spi_burst_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int DUM   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n = 1'b1;
  logic MOSI = 1'b0;
  logic MISO;

  always #5 clk = ~clk;

  spi_burst_ram_slave #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MEM_DEPTH   (DEPTH),
    .DUMMY_CYCLES(DUM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  logic [DW-1:0] model_mem [DEPTH];
  logic [AW-1:0] model_ptr;
  int checks = 0;
  int passed = 0;
  int zero_err;
  logic miso_s;
  bit pend;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_v;

  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  addr;
    int          n;
    logic [63:0] w;
    int          abort;
    logic [7:0]  exp_ptr;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 8'd1;
  endfunction

  task automatic bit_cyc(input logic ss, input logic m);
    SS_n = ss;
    MOSI = m;
    @(posedge clk);
    @(negedge clk);
    miso_s = MISO;
  endtask

  task automatic step(input logic ss, input logic m);
    bit_cyc(ss, m);
    if (miso_s !== 1'b0) zero_err++;
    if (pend) begin
      check("wr_commit", 32'(dut.u_ram.mem[pend_a]), 32'(pend_v));
      pend = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [1:0] cmd, input logic [AW-1:0] addr, input bit with_addr);
    step(1'b0, 1'b0);
    step(1'b0, cmd[1]);
    step(1'b0, cmd[0]);
    if (with_addr) for (int i = AW - 1; i >= 0; i--) step(1'b0, addr[i]);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int n, input logic [63:0] w, input int abort_bits);
    logic [AW-1:0] p;
    logic [DW-1:0] wd;
    int kmax;
    zero_err = 0;
    pend = 1'b0;
    send_hdr(CMD_WR, addr, 1'b1);
    p = addr;
    kmax = n + ((abort_bits > 0) ? 1 : 0);
    for (int k = 0; k < kmax; k++) begin
      wd = w[63 - 8 * k -: 8];
      for (int b = DW - 1; b >= 0; b--) begin
        if (k == n && (DW - 1 - b) >= abort_bits) break;
        step(1'b0, wd[b]);
        if (b == 0) begin
          check("wr_not_early", 32'(dut.u_ram.mem[p]), 32'(model_mem[p]));
          pend = 1'b1;
          pend_a = p;
          pend_v = wd;
          model_mem[p] = wd;
          p = nxt(p);
        end
      end
    end
    step(1'b1, 1'b0);
    if (abort_bits > 0) check("abort_idle", 32'(dut.state_q), 32'(IDLE));
    step(1'b1, 1'b0);
    model_ptr = p;
    check("wr_miso_zero", zero_err, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int n, input logic [63:0] e, input string tag);
    logic [DW-1:0] got;
    logic [AW-1:0] p;
    zero_err = 0;
    send_hdr(CMD_RD, addr, 1'b1);
    for (int i = 0; i < DUM; i++) step(1'b0, 1'($urandom));
    p = addr;
    for (int k = 0; k < n; k++) begin
      got = '0;
      for (int b = 0; b < DW; b++) begin
        bit_cyc(1'b0, 1'($urandom));
        got = {got[DW-2:0], miso_s};
      end
      check(tag, 32'(got), 32'(e[63 - 8 * k -: 8]));
      p = nxt(p);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    model_ptr = p;
    check("rd_miso_zero", zero_err, 0);
  endtask

  task automatic do_status(input string tag, input logic [AW-1:0] exp);
    logic [AW-1:0] got;
    zero_err = 0;
    got = '0;
    send_hdr(CMD_STAT, '0, 1'b0);
    for (int i = 0; i < AW; i++) begin
      bit_cyc(1'b0, 1'($urandom));
      got = {got[AW-2:0], miso_s};
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check(tag, 32'(got), 32'(exp));
    check("stat_miso_zero", zero_err, 0);
  endtask

  task automatic do_rsv(input int nbits);
    zero_err = 0;
    send_hdr(CMD_RSV, '0, 1'b0);
    for (int i = 0; i < nbits; i++) step(1'b0, 1'($urandom));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("rsv_miso_zero", zero_err, 0);
  endtask

  task automatic mem_compare(input string tag);
    int m = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.u_ram.mem[i] !== model_mem[i]) m++;
    check(tag, m, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [63:0] w, e;
    logic [AW-1:0] p;
    int op, n, ab;

    tbl[0] = '{CMD_WR,  8'h10, 3,  64'hA53CFF00_00000000, 0, 8'h13};
    tbl[1] = '{CMD_RD,  8'h10, 3,  64'hA53CFF00_00000000, 0, 8'h13};
    tbl[2] = '{CMD_WR,  8'hFF, 2,  64'h11220000_00000000, 0, 8'h01};
    tbl[3] = '{CMD_RD,  8'hFF, 2,  64'h11220000_00000000, 0, 8'h01};
    tbl[4] = '{CMD_RSV, 8'h00, 16, 64'h0,                 0, 8'h01};
    tbl[5] = '{CMD_WR,  8'h40, 1,  64'h5AC30000_00000000, 5, 8'h41};
    tbl[6] = '{CMD_RD,  8'h40, 2,  64'h5A770000_00000000, 0, 8'h42};

    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = DW'($urandom);
      dut.u_ram.mem[i] = model_mem[i];
    end
    model_mem[8'h41] = 8'h77;
    dut.u_ram.mem[8'h41] = 8'h77;
    model_ptr = '0;
    pend = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_miso", 32'(MISO), 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_status("reset_ptr", 8'h00);

    for (int i = 0; i < 7; i++) begin
      case (tbl[i].cmd)
        CMD_WR:  do_write(tbl[i].addr, tbl[i].n, tbl[i].w, tbl[i].abort);
        CMD_RD:  do_read(tbl[i].addr, tbl[i].n, tbl[i].w, "tbl_rd");
        CMD_RSV: do_rsv(tbl[i].n);
        default: ;
      endcase
      do_status("tbl_ptr", tbl[i].exp_ptr);
      mem_compare("tbl_mem");
    end

    // Asynchronous reset in the middle of a read while MISO is high.
    zero_err = 0;
    send_hdr(CMD_RD, 8'h10, 1'b1);
    for (int i = 0; i < DUM; i++) step(1'b0, 1'b0);
    bit_cyc(1'b0, 1'b0);
    check("rd_first_bit", 32'(miso_s), 32'(model_mem[8'h10][DW-1]));
    rst_n = 1'b0;
    #1;
    check("async_reset_miso", 32'(MISO), 0);
    SS_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_ptr = '0;
    do_status("post_reset_ptr", 8'h00);

    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 3);
      a  = AW'($urandom);
      n  = $urandom_range(1, 6);
      w  = {$urandom, $urandom};
      case (op)
        0: begin
          ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DW - 1) : 0;
          do_write(a, n, w, ab);
        end
        1: begin
          e = '0;
          p = a;
          for (int k = 0; k < n; k++) begin
            e[63 - 8 * k -: 8] = model_mem[p];
            p = nxt(p);
          end
          do_read(a, n, e, "rnd_rd");
        end
        2: do_rsv($urandom_range(0, 20));
        default: do_status("rnd_ptr", model_ptr);
      endcase
    end
    mem_compare("rnd_mem");
    do_status("final_ptr", model_ptr);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
